// File: rtl/wb_sequencer.sv
// Writeback sequencer: selects ALU vs memory data for the register file, runs the
// memory req/ready handshake with a bounded wait, and counts retired writebacks.
module wb_sequencer #(
  parameter int unsigned RA_W    = 5,
  parameter int unsigned TO_W    = 4,
  parameter int unsigned TIMEOUT = 12,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic             instr_load,
  input  logic             instr_store,
  input  logic [RA_W-1:0]  instr_rd,
  output logic             instr_ready,
  output logic             mem_req,
  output logic             mem_we,
  input  logic             mem_ready,
  output logic             sel_dat,
  output logic             reg_we,
  output logic [RA_W-1:0]  reg_waddr,
  output logic             err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] wb_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALU_WB,
    S_MEM_WAIT,
    S_MEM_WB,
    S_ERR
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [RA_W-1:0]  rd_q;
  logic             store_q;
  logic [TO_W-1:0]  timer;
  logic [CNT_W-1:0] wb_count_q;
  logic             accept;

  assign accept = instr_valid & (state == S_IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept)
          state_nxt = (instr_load | instr_store) ? S_MEM_WAIT : S_ALU_WB;
      end
      S_ALU_WB: state_nxt = S_IDLE;
      S_MEM_WAIT: begin
        // A completion on the final allowed cycle still beats the timeout.
        if (mem_ready)
          state_nxt = store_q ? S_IDLE : S_MEM_WB;
        else if (timer == TO_LAST)
          state_nxt = S_ERR;
      end
      S_MEM_WB: state_nxt = S_IDLE;
      S_ERR: begin
        if (err_clr)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    sel_dat     = 1'b0;
    reg_we      = 1'b0;
    err         = 1'b0;
    unique case (state)
      S_IDLE:     instr_ready = 1'b1;
      S_ALU_WB:   reg_we      = (rd_q != '0);
      S_MEM_WAIT: begin
        mem_req = 1'b1;
        mem_we  = store_q;
      end
      S_MEM_WB: begin
        sel_dat = 1'b1;
        reg_we  = (rd_q != '0);
      end
      S_ERR:      err = 1'b1;
      default:    instr_ready = 1'b0;
    endcase
  end

  assign reg_waddr = rd_q;
  assign wb_count  = wb_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rd_q       <= '0;
      store_q    <= 1'b0;
      timer      <= '0;
      wb_count_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rd_q    <= instr_rd;
        store_q <= instr_store & ~instr_load;
      end
      if (state == S_MEM_WAIT)
        timer <= timer + 1'b1;
      else
        timer <= '0;
      wb_count_q <= wb_count_q + CNT_W'(reg_we);
    end
  end

endmodule
